// File: rtl/dmem_arbiter_pkg.sv
// Shared types and widths for the data-memory arbiter.
// Holds FSM/owner enums and the wrapped beat-address helper.
package dmem_arb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;
  localparam int CNT_W  = LEN_W + 1;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_A,
    OWN_B
  } owner_t;

  // Base plus beat index, modulo memory depth.
  function automatic logic [ADDR_W-1:0] wrap_addr(
    input logic [ADDR_W-1:0] base,
    input logic [CNT_W-1:0]  idx
  );
    logic [ADDR_W+CNT_W-1:0] sum;
    sum = (ADDR_W + CNT_W)'(base)
        + (ADDR_W + CNT_W)'(idx);
    return sum[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between CPU port A, DMA port B, memory and arbiter.
// master: sources and memory side; slave: the arbiter.
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  logic              A_REQ;
  logic              A_WE;
  logic [ADDR_W-1:0] A_ADDR;
  logic [DATA_W-1:0] A_WDATA;
  logic              A_GNT;
  logic              A_RVALID;
  logic [DATA_W-1:0] A_RDATA;

  logic              B_START;
  logic              B_WE;
  logic [ADDR_W-1:0] B_ADDR;
  logic [LEN_W-1:0]  B_LEN;
  logic [DATA_W-1:0] B_WDATA;
  logic              B_WREADY;
  logic              B_RVALID;
  logic [DATA_W-1:0] B_RDATA;
  logic              B_BUSY;
  logic              B_DONE;

  logic              M_MEMREAD;
  logic              M_MEMWRITE;
  logic [31:0]       M_ADDR;
  logic [DATA_W-1:0] M_WDATA;
  logic [DATA_W-1:0] M_RDATA;

  modport master (
    output A_REQ, A_WE, A_ADDR, A_WDATA,
    input  A_GNT, A_RVALID, A_RDATA,
    output B_START, B_WE, B_ADDR, B_LEN,
    output B_WDATA,
    input  B_WREADY, B_RVALID, B_RDATA,
    input  B_BUSY, B_DONE,
    input  M_MEMREAD, M_MEMWRITE, M_ADDR,
    input  M_WDATA,
    output M_RDATA
  );

  modport slave (
    input  A_REQ, A_WE, A_ADDR, A_WDATA,
    output A_GNT, A_RVALID, A_RDATA,
    input  B_START, B_WE, B_ADDR, B_LEN,
    input  B_WDATA,
    output B_WREADY, B_RVALID, B_RDATA,
    output B_BUSY, B_DONE,
    output M_MEMREAD, M_MEMWRITE, M_ADDR,
    output M_WDATA,
    input  M_RDATA
  );

endinterface

// File: rtl/dmem_burst_agen.sv
// Burst address generator: latches base/len/dir, counts beats.
// Ports: start/advance in; wrapped addr, last flag, dir out.
module dmem_burst_agen
  import dmem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              we,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              we_q
);

  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      len_q  <= '0;
      we_q   <= 1'b0;
      idx    <= '0;
    end else if (start) begin
      base_q <= base;
      len_q  <= len;
      we_q   <= we;
      idx    <= '0;
    end else if (advance) begin
      idx <= last ? '0 : idx + CNT_W'(1);
    end
  end

  assign last = (idx == CNT_W'(len_q));
  assign addr = wrap_addr(base_q, idx);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU single beats vs DMA bursts.
// Ports: CLK, RESET_N (async low), bus (slave modport).
module dmem_arbiter
  import dmem_arb_pkg::*;
(
  input  logic           CLK,
  input  logic           RESET_N,
  dmem_arbiter_if.slave  bus
);

  state_t            state;
  owner_t            last_owner;
  owner_t            owner;
  logic              in_idle;
  logic              in_burst;
  logic              a_sel;
  logic              b_sel;
  logic              b_start;
  logic              b_last;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [ADDR_W-1:0] m_addr;
  logic              a_rvalid;
  logic              b_rvalid;
  logic              b_done;
  logic [DATA_W-1:0] a_rdata;
  logic [DATA_W-1:0] b_rdata;

  // Gating with RESET_N keeps every M_* output low during reset.
  assign in_idle  = RESET_N && (state == IDLE);
  assign in_burst = RESET_N && (state == BURST);

  always_comb begin
    owner = OWN_NONE;
    unique case (1'b1)
      in_idle: begin
        if (bus.A_REQ) owner = OWN_A;
      end
      in_burst: begin
        if (bus.A_REQ && last_owner == OWN_B)
          owner = OWN_A;
        else
          owner = OWN_B;
      end
      default: owner = OWN_NONE;
    endcase
  end

  assign a_sel   = (owner == OWN_A);
  assign b_sel   = (owner == OWN_B);
  assign b_start = bus.B_START && (state == IDLE);

  dmem_burst_agen u_agen (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .start   (b_start),
    .we      (bus.B_WE),
    .base    (bus.B_ADDR),
    .len     (bus.B_LEN),
    .advance (b_sel),
    .addr    (b_addr),
    .last    (b_last),
    .we_q    (b_we)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      last_owner <= OWN_A;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      b_done     <= 1'b0;
    end else begin
      a_rvalid <= a_sel && !bus.A_WE;
      b_rvalid <= b_sel && !b_we;
      if (a_sel && !bus.A_WE) a_rdata <= bus.M_RDATA;
      if (b_sel && !b_we)     b_rdata <= bus.M_RDATA;
      b_done <= b_sel && b_last;
      if (owner != OWN_NONE) last_owner <= owner;
      unique case (state)
        IDLE: begin
          // Every burst opens with B priority.
          if (bus.B_START) begin
            state      <= BURST;
            last_owner <= OWN_A;
          end
        end
        BURST: begin
          if (b_sel && b_last) state <= IDLE;
        end
      endcase
    end
  end

  assign m_addr = a_sel ? bus.A_ADDR
                : b_sel ? b_addr
                : '0;

  assign bus.A_GNT      = a_sel;
  assign bus.A_RVALID   = a_rvalid;
  assign bus.A_RDATA    = a_rdata;
  assign bus.B_WREADY   = b_sel && b_we;
  assign bus.B_RVALID   = b_rvalid;
  assign bus.B_RDATA    = b_rdata;
  assign bus.B_BUSY     = (state == BURST);
  assign bus.B_DONE     = b_done;
  assign bus.M_MEMWRITE = (a_sel && bus.A_WE)
                        || (b_sel && b_we);
  assign bus.M_MEMREAD  = (a_sel && !bus.A_WE)
                        || (b_sel && !b_we);
  assign bus.M_ADDR     = 32'(m_addr);
  assign bus.M_WDATA    = a_sel ? bus.A_WDATA
                        : b_sel ? bus.B_WDATA
                        : '0;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port arbiter and sequencer for the 32-word data memory. It shares the memory between the CPU MEM stage (port A, single-beat) and a DMA/debug engine (port B, incrementing bursts). Port B uses a per-beat round-robin so the CPU stalls at most one cycle. The block sits between the pipeline's MEM stage and the data memory, driving its MEMREAD/MEMWRITE/ADDR/WRITE_DATA inputs and sampling its combinational READ_DATA.

## Interface
- ADDR_W, 5, word-address width; memory depth 2^ADDR_W.
- DATA_W, 32, data width.
- LEN_W, 4, burst length field width; beats = B_LEN+1.

Ports:
- CLK  in  1  system clock; all state on posedge. Memory writes on its own negedge.
- RESET_N  in  1  asynchronous, active-low reset.
- A_REQ  in  1  CPU access request; held until A_GNT.
- A_WE  in  1  1 = write, 0 = read.
- A_ADDR  in  ADDR_W  CPU word address.
- A_WDATA  in  DATA_W  CPU write data.
- A_GNT  out  1  access presented to memory this cycle (combinational).
- A_RVALID  out  1  read data valid; one cycle after a granted read.
- A_RDATA  out  DATA_W  registered read data.
- B_START  in  1  one-cycle burst start pulse.
- B_WE  in  1  burst direction.
- B_ADDR  in  ADDR_W  burst base address.
- B_LEN  in  LEN_W  beats minus one.
- B_WDATA  in  DATA_W  write data for the current beat.
- B_WREADY  out  1  current write beat consumed; source advances B_WDATA.
- B_RVALID  out  1  read beat data valid.
- B_RDATA  out  DATA_W  registered read beat data.
- B_BUSY  out  1  burst in progress.
- B_DONE  out  1  one-cycle pulse after the last beat.
- M_MEMREAD, M_MEMWRITE  out  1  memory controls.
- M_ADDR  out  32  zero-extended word address.
- M_WDATA  out  DATA_W  memory write data.
- M_RDATA  in  DATA_W  memory combinational read data.

## Operation
States:
- IDLE: no burst is active. A_REQ is granted in the same cycle. B_START latches base, length and direction, then moves to BURST. The first beat issues the cycle after B_START.
- BURST: B_BUSY=1. Each cycle exactly one of A or B owns the memory.
  - A wins if A_REQ=1 and last_owner=B. Otherwise B issues a beat.
  - After the final beat completes, the block returns to IDLE and pulses B_DONE the next cycle.
- B_START while B_BUSY=1 is ignored.
- last_owner resets to A, so on contention B gets the first beat after a burst starts.

Beat addressing and counting:
- Beat address = (base + idx) mod 2^ADDR_W. Wrap-around is silent.
- Beat counter width is LEN_W+1. The burst ends when idx == latched B_LEN.

Memory side:
- M_MEMWRITE = granted write. M_MEMREAD = granted read.
- M_ADDR and M_WDATA come from the owner.
- All M_* outputs are 0 when no port owns the memory.

Read return:
- M_RDATA is registered into A_RDATA or B_RDATA at the posedge ending the grant cycle.
- The matching RVALID is high for exactly that following cycle. RDATA holds its value until the next read.

Write beats: B_WREADY is asserted combinationally in each B write-beat cycle.

Ordering: same-address A/B accesses take effect in grant order. A read granted after a write sees the new data, because the write lands on the intervening negedge.

Reset (RESET_N low, asynchronous, including mid-burst):
- State returns to IDLE, counters clear and last_owner=A.
- All outputs go to 0 immediately, including RDATA registers and M_* controls.
- The aborted burst produces no B_DONE.

## Timing
- A latency: grant in the request cycle when A is uncontended. Maximum wait is 1 cycle during a burst.
- B latency: first beat at cycle N+1 after B_START at N. An uncontended burst takes B_LEN+1 cycles. A fully contended burst takes at most 2·(B_LEN+1) cycles.
- Read data: valid 1 cycle after the grant.
- B_DONE: 1 cycle after the final beat's grant.
- B_START is accepted again in the cycle B_DONE is high.

## Structure
- Shared package dmem_arb_pkg:
  - state enum {IDLE, BURST}.
  - owner enum {OWN_NONE, OWN_A, OWN_B}.
  - default widths ADDR_W/DATA_W/LEN_W.
- Sub-module dmem_burst_agen holds the base/length latch, beat counter, wrapped address generation and the last-beat flag.
- The arbiter FSM, round-robin and read-return registers stay in the top level.

## Test plan
- CPU write then read: A writes 0xDEADBEEF to addr 3, then reads addr 3. Expect A_GNT in both request cycles, then A_RVALID=1 with A_RDATA=0xDEADBEEF one cycle later. No B activity.
- Wrapping read burst: preload addr 30,31,0,1 with 0x1E,0x1F,0x00,0x01. Issue B_START with B_ADDR=30, B_LEN=3, read. Expect M_ADDR 30,31,0,1 on cycles N+1..N+4, B_RVALID data 0x1E,0x1F,0x00,0x01, and B_DONE at N+5.
- Contention: issue an 8-beat write burst with A_REQ held high for 4 consecutive reads. Grants alternate B,A,B,A,B,A,B,A, then B continues. Each A read waits ≤1 cycle and B_DONE arrives after 12 busy cycles.
- Start while busy: a second B_START mid-burst with a different B_ADDR is ignored. The address sequence is unchanged and only one B_DONE is produced.
- Reset mid-burst: drop RESET_N at beat 2 of 6 and check asynchronously:
  - M_MEMWRITE/M_MEMREAD, B_BUSY and all RVALIDs are 0 immediately.
  - No B_DONE is produced.
  - After release, a new burst starts from idx 0.
- Same-address ordering: during a B write burst to addr 5 of 0x55, an A read of addr 5 is granted after the B beat and returns 0x55. If A is granted first, it returns the old value.
